// File: rtl/fp32_to_int_seq_if.sv
// Handshake bundle for the FP32-to-integer converter: input operand channel
// and result channel, each with its own valid/ready pair.
interface fp32_to_int_seq_if #(
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [2:0]       out_flags;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp32_to_int_seq.sv
// Iterative FP32 -> signed integer converter, truncating toward zero and
// saturating out-of-range values; one shift position per clock.
module fp32_to_int_seq #(
  parameter int unsigned OUT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  fp32_to_int_seq_if.slave   bus
);

  localparam int unsigned MAG_W = ((OUT_W > 24) ? OUT_W : 24) + 1;
  localparam int unsigned CNT_W = 7;
  localparam logic [MAG_W-1:0] MIN_MAG = {{(MAG_W-1){1'b0}}, 1'b1} << (OUT_W - 1);
  localparam logic [MAG_W-1:0] MAX_MAG = MIN_MAG - {{(MAG_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIX,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               sign_q, sign_d;
  logic               sticky_q, sticky_d;
  logic [2:0]         flag_q, flag_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [2:0]         out_flags_q, out_flags_d;

  logic               sgn_v;
  logic [7:0]         exp_v;
  logic [22:0]        frac_v;
  int                 e_v;

  assign sgn_v  = bus.in_data[31];
  assign exp_v  = bus.in_data[30:23];
  assign frac_v = bus.in_data[22:0];
  assign e_v    = int'(exp_v) - 127;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    sign_d      = sign_q;
    sticky_d    = sticky_q;
    flag_d      = flag_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d   = sgn_v;
          sticky_d = 1'b0;
          flag_d   = 3'b000;
          left_d   = 1'b0;
          cnt_d    = '0;
          mag_d    = MAG_W'({1'b1, frac_v});
          // Special cases preload a signed magnitude and pass through FIX so
          // that every result takes at least one cycle to appear.
          if (exp_v == 8'hFF) begin
            state_d = FIX;
            flag_d  = 3'b100;
            sign_d  = sgn_v && (frac_v == '0);
            mag_d   = (sgn_v && (frac_v == '0)) ? MIN_MAG : MAX_MAG;
          end else if ((exp_v == 8'h00) || (e_v < 0)) begin
            state_d  = FIX;
            mag_d    = '0;
            sticky_d = ({exp_v, frac_v} != '0);
          end else if (e_v >= int'(OUT_W) - 1) begin
            state_d = FIX;
            if (sgn_v && (e_v == int'(OUT_W) - 1) && (frac_v == '0)) begin
              mag_d = MIN_MAG;
            end else begin
              flag_d = 3'b010;
              mag_d  = sgn_v ? MIN_MAG : MAX_MAG;
            end
          end else if (e_v < 23) begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(23 - e_v);
          end else if (e_v == 23) begin
            state_d = FIX;
          end else begin
            state_d = SHIFT;
            left_d  = 1'b1;
            cnt_d   = CNT_W'(e_v - 23);
          end
        end
      end

      SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          sticky_d = sticky_q | mag_q[0];
          mag_d    = mag_q >> 1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        out_data_d  = sign_q ? (-mag_q[OUT_W-1:0]) : mag_q[OUT_W-1:0];
        out_flags_d = {flag_q[2:1], flag_q[0] | sticky_q};
        state_d     = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      sign_q      <= 1'b0;
      sticky_q    <= 1'b0;
      flag_q      <= '0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      sign_q      <= sign_d;
      sticky_q    <= sticky_d;
      flag_q      <= flag_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// Directed and randomized checks of fp32_to_int_seq against a value-level
// reference model of C-style float-to-int conversion with saturation.
module tb_fp32_to_int_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp32_to_int_seq_if #(.OUT_W(32)) bus ();

  fp32_to_int_seq #(.OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: real value = M * 2^(e-23), truncated, then range-checked.
  function automatic void model(input logic [31:0] x, output logic [31:0] d,
                                output logic [2:0] f, output int lat);
    int     e;
    longint m, v;
    logic   inexact;
    e = int'(x[30:23]) - 127;
    m = longint'({1'b1, x[22:0]});
    inexact = 1'b0;
    lat = 1;
    if (x[30:23] == 8'hFF) begin
      d = (x[31] && x[22:0] == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      f = 3'b100;
    end else if (x[30:23] == 8'h00 || e < 0) begin
      d = 32'd0;
      f = (x[30:0] != 0) ? 3'b001 : 3'b000;
    end else if (e > 40) begin
      d = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      f = 3'b010;
    end else begin
      if (e >= 23) begin
        v = m * (longint'(1) << (e - 23));
      end else begin
        v = m / (longint'(1) << (23 - e));
        inexact = (m % (longint'(1) << (23 - e))) != 0;
      end
      if (x[31]) v = -v;
      if (v > 64'sd2147483647) begin
        d = 32'h7FFF_FFFF;
        f = 3'b010;
      end else if (v < -64'sd2147483648) begin
        d = 32'h8000_0000;
        f = 3'b010;
      end else begin
        d = v[31:0];
        f = {2'b00, inexact};
        if (e < 31) lat = ((e >= 23) ? (e - 23) : (23 - e)) + 1;
      end
    end
  endfunction

  // One transaction: accept, measure latency, check result, optional backpressure.
  task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] exp_d,
                         input logic [2:0] exp_f, input int exp_lat, input int hold);
    int guard;
    int lat;
    logic [31:0] d0;
    logic [2:0]  f0;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      step();
      guard++;
    end
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = (hold == 0);
    bus.in_data   = x;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, 64'(bus.out_data), 64'(exp_d));
    chk({tag, "_flags"}, 64'(bus.out_flags), 64'(exp_f));
    if (hold > 0) begin
      d0 = bus.out_data;
      f0 = bus.out_flags;
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        step();
        chk({tag, "_bp_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_bp_data"}, 64'(bus.out_data), 64'(d0));
        chk({tag, "_bp_flags"}, 64'(bus.out_flags), 64'(f0));
        chk({tag, "_bp_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    step();
    chk({tag, "_release"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] x, md;
    logic [2:0]  mf;
    int          ml;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_flags", 64'(bus.out_flags), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    run_one("one",      32'h3F80_0000, 32'h0000_0001, 3'b000, 24, 0);
    run_one("neg2p5",   32'hC020_0000, 32'hFFFF_FFFE, 3'b001, 23, 0);
    run_one("k0",       32'h4B00_0001, 32'd8388609,   3'b000, 1,  0);
    run_one("pos2p31",  32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1,  0);
    run_one("neg2p31",  32'hCF00_0000, 32'h8000_0000, 3'b000, 1,  0);
    run_one("nan",      32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100, 1,  0);
    run_one("ninf",     32'hFF80_0000, 32'h8000_0000, 3'b100, 1,  0);
    run_one("denorm",   32'h0000_0001, 32'h0000_0000, 3'b001, 1,  0);
    run_one("negzero",  32'h8000_0000, 32'h0000_0000, 3'b000, 1,  0);
    run_one("big_left", 32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 8,  0);
    run_one("half",     32'h3F00_0000, 32'h0000_0000, 3'b001, 1,  0);
    run_one("backpres", 32'hC2F6_0000, 32'hFFFF_FF85, 3'b000, 18, 5);

    // Abort a conversion mid-shift with reset.
    bus.in_data  = 32'h3F80_0000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    chk("abort_in_ready_busy", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_out_data", 64'(bus.out_data), 64'd0);
    chk("abort_out_flags", 64'(bus.out_flags), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    run_one("after_rst", 32'h42F6_0000, 32'd123, 3'b000, 18, 0);

    for (int i = 0; i < 80; i++) begin
      x = $urandom;
      if (i % 4 != 0) x[30:23] = 8'($urandom_range(120, 162));
      model(x, md, mf, ml);
      run_one("rand", x, md, mf, ml, (i % 16 == 5) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
